// File: rtl/score_ctrl_pkg.sv
// Shared game definitions for the score path: state encoding, score width and counter defaults.
`define SCORELEN 12

package score_ctrl_pkg;

  localparam int unsigned SCORE_W_DEF     = `SCORELEN + 1;
  localparam int unsigned SCORE_MAX_DEF   = 6399;
  localparam int unsigned LEVEL_STEP_DEF  = 100;
  localparam int unsigned LEVEL_MAX_DEF   = 7;
  localparam int unsigned BLINK_TICKS_DEF = 8;
  localparam int unsigned LEVEL_W         = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_e;

endpackage

// File: rtl/score_sat_counter.sv
// Up-counter with clear and enable that either saturates at max_i or wraps to zero (WRAP=1).
module score_sat_counter #(
  parameter int unsigned W    = 8,
  parameter bit          WRAP = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] next_c,
  output logic         at_max_en_c
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // at_max_en_c marks an enabled step while at max: a wrap event, or a swallowed saturated step
  always_comb begin
    count_d     = count_q;
    at_max_en_c = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      if (count_q < max_i) begin
        count_d = count_q + W'(1);
      end else begin
        at_max_en_c = 1'b1;
        if (WRAP) count_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
  assign next_c  = count_d;

endmodule

// File: rtl/score_ctrl.sv
// Score sequencer: counts score from game ticks, tracks the session high score and speed level,
// and drives the display bus, alternating final and high score after game over.
module score_ctrl
  import score_ctrl_pkg::*;
#(
  parameter int unsigned SCORE_W     = SCORE_W_DEF,
  parameter int unsigned SCORE_MAX   = SCORE_MAX_DEF,
  parameter int unsigned LEVEL_STEP  = LEVEL_STEP_DEF,
  parameter int unsigned LEVEL_MAX   = LEVEL_MAX_DEF,
  parameter int unsigned BLINK_TICKS = BLINK_TICKS_DEF
) (
  input  logic               clk2,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               hit,
  input  logic               tick,
  output logic [SCORE_W-1:0] score_out,
  output logic [SCORE_W-1:0] hi_score,
  output logic [LEVEL_W-1:0] level,
  output logic               running,
  output logic               game_over,
  output logic               show_hi,
  output logic               new_record
);

  localparam int unsigned STEP_W  = $clog2(LEVEL_STEP + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);

  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   hi_q, hi_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic                 record_q, record_d;
  logic                 show_q, show_d;
  logic                 running_q, game_over_q;
  logic [SCORE_W-1:0]   score_out_q;

  logic                 score_clr, score_en;
  logic                 blink_clr, blink_en;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 score_sat_c;
  logic                 step_en, step_wrap_c;
  logic                 blink_wrap_c;
  logic [STEP_W-1:0]    step_cnt, step_next;
  logic [BLINK_W-1:0]   blink_cnt, blink_next;
  logic                 unused_cnt;

  score_sat_counter #(.W(SCORE_W), .WRAP(1'b0)) u_score (
    .clk        (clk2),
    .rst_n      (reset),
    .clr_i      (score_clr),
    .en_i       (score_en),
    .max_i      (SCORE_W'(SCORE_MAX)),
    .count_o    (score_q),
    .next_c     (score_d),
    .at_max_en_c(score_sat_c)
  );

  // a tick swallowed by score saturation must not advance the level
  assign step_en = score_en & ~score_sat_c;

  score_sat_counter #(.W(STEP_W), .WRAP(1'b1)) u_step (
    .clk        (clk2),
    .rst_n      (reset),
    .clr_i      (score_clr),
    .en_i       (step_en),
    .max_i      (STEP_W'(LEVEL_STEP - 1)),
    .count_o    (step_cnt),
    .next_c     (step_next),
    .at_max_en_c(step_wrap_c)
  );

  score_sat_counter #(.W(BLINK_W), .WRAP(1'b1)) u_blink (
    .clk        (clk2),
    .rst_n      (reset),
    .clr_i      (blink_clr),
    .en_i       (blink_en),
    .max_i      (BLINK_W'(BLINK_TICKS - 1)),
    .count_o    (blink_cnt),
    .next_c     (blink_next),
    .at_max_en_c(blink_wrap_c)
  );

  assign unused_cnt = ^{step_cnt, step_next, blink_cnt, blink_next};

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    level_d   = level_q;
    record_d  = record_q;
    show_d    = show_q;
    score_clr = 1'b0;
    score_en  = 1'b0;
    blink_clr = (state_q != OVER);
    blink_en  = 1'b0;

    case (state_q)
      IDLE: begin
        score_clr = 1'b1;
        level_d   = '0;
        if (start) state_d = RUN;
      end
      RUN: begin
        // hit beats pause beats tick; the tick that lands with hit or pause is dropped
        if (hit) begin
          state_d = OVER;
          if (score_q > hi_q) begin
            hi_d     = score_q;
            record_d = 1'b1;
          end else begin
            record_d = 1'b0;
          end
        end else if (pause) begin
          state_d = PAUSE;
        end else if (tick) begin
          score_en = 1'b1;
        end
      end
      PAUSE: begin
        if (pause) state_d = RUN;
      end
      OVER: begin
        if (start) begin
          state_d   = RUN;
          score_clr = 1'b1;
          blink_clr = 1'b1;
          level_d   = '0;
          show_d    = 1'b0;
          record_d  = 1'b0;
        end else begin
          blink_en = tick;
          if (blink_wrap_c) show_d = ~show_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (step_wrap_c && (level_q < LEVEL_W'(LEVEL_MAX))) level_d = level_q + LEVEL_W'(1);
  end

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      level_q     <= '0;
      record_q    <= 1'b0;
      show_q      <= 1'b0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
      score_out_q <= '0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      level_q     <= level_d;
      record_q    <= record_d;
      show_q      <= show_d;
      running_q   <= (state_d == RUN);
      game_over_q <= (state_d == OVER);
      score_out_q <= show_d ? hi_d : score_d;
    end
  end

  assign score_out  = score_out_q;
  assign hi_score   = hi_q;
  assign level      = level_q;
  assign running    = running_q;
  assign game_over  = game_over_q;
  assign show_hi    = show_q;
  assign new_record = record_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl: a vector table for start/tick/pause behaviour plus
// hand-written sequences for level, saturation, record, blink and reset.
module tb_score_ctrl;

  typedef struct packed {
    logic [12:0] score_out;
    logic [12:0] hi_score;
    logic [2:0]  level;
    logic        running;
    logic        game_over;
    logic        show_hi;
    logic        new_record;
  } outs_t;

  typedef struct {
    logic  start;
    logic  pause;
    logic  hit;
    logic  tick;
    outs_t exp;
  } vec_t;

  logic        clk2 = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        hit = 1'b0;
  logic        tick = 1'b0;
  logic [12:0] score_out;
  logic [12:0] hi_score;
  logic [2:0]  level;
  logic        running;
  logic        game_over;
  logic        show_hi;
  logic        new_record;

  int errors = 0;
  int checks = 0;

  score_ctrl dut (
    .clk2      (clk2),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .hit       (hit),
    .tick      (tick),
    .score_out (score_out),
    .hi_score  (hi_score),
    .level     (level),
    .running   (running),
    .game_over (game_over),
    .show_hi   (show_hi),
    .new_record(new_record)
  );

  always #5 clk2 = ~clk2;

  function automatic outs_t mk(input int so, input int hs, input int lv, input logic r,
                               input logic go, input logic sh, input logic nr);
    outs_t o;
    o.score_out  = 13'(so);
    o.hi_score   = 13'(hs);
    o.level      = 3'(lv);
    o.running    = r;
    o.game_over  = go;
    o.show_hi    = sh;
    o.new_record = nr;
    return o;
  endfunction

  task automatic chk(input string name, input outs_t exp);
    outs_t act;
    act = {score_out, hi_score, level, running, game_over, show_hi, new_record};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got score_out=%0d hi=%0d lvl=%0d run=%0b over=%0b show=%0b rec=%0b, want score_out=%0d hi=%0d lvl=%0d run=%0b over=%0b show=%0b rec=%0b",
               name, act.score_out, act.hi_score, act.level, act.running, act.game_over,
               act.show_hi, act.new_record, exp.score_out, exp.hi_score, exp.level,
               exp.running, exp.game_over, exp.show_hi, exp.new_record);
    end
  endtask

  task automatic cyc(input logic s, input logic p, input logic h, input logic t);
    start = s;
    pause = p;
    hit   = h;
    tick  = t;
    @(posedge clk2);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic reset_pulse();
    start = 1'b0; pause = 1'b0; hit = 1'b0; tick = 1'b0;
    reset = 1'b0;
    #2;
  endtask

  vec_t vecs[13];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got no end, want end of test");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 0, 0, 0)};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 1, 0, 0, 0)};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(2, 0, 0, 1, 0, 0, 0)};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(3, 0, 0, 1, 0, 0, 0)};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(4, 0, 0, 1, 0, 0, 0)};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(5, 0, 0, 1, 0, 0, 0)};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(5, 0, 0, 1, 0, 0, 0)};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, mk(5, 0, 0, 0, 0, 0, 0)};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(5, 0, 0, 0, 0, 0, 0)};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(5, 0, 0, 0, 0, 0, 0)};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(5, 0, 0, 0, 0, 0, 0)};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(5, 0, 0, 1, 0, 0, 0)};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(6, 0, 0, 1, 0, 0, 0)};

    // reset values
    repeat (2) @(posedge clk2);
    #1;
    chk("reset_state", mk(0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("idle_ignores_tick", mk(0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].start, vecs[i].pause, vecs[i].hit, vecs[i].tick);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // paused for 20 ticks with a hit and a start in the middle
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("pause_enter", mk(6, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      cyc(i == 15, 1'b0, i == 9, 1'b1);
      chk($sformatf("pause_frozen%0d", i), mk(6, 0, 0, 0, 0, 0, 0));
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("pause_exit", mk(6, 0, 0, 1, 0, 0, 0));
    ticks(3);
    chk("run_after_pause", mk(9, 0, 0, 1, 0, 0, 0));

    // asynchronous reset mid-run, seen before the next edge
    reset_pulse();
    chk("reset_mid_run", mk(0, 0, 0, 0, 0, 0, 0));
    @(posedge clk2);
    #1;
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_after_reset", mk(0, 0, 0, 0, 0, 0, 0));

    // level steps on the 100th tick
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(99);
    chk("level_before_100", mk(99, 0, 0, 1, 0, 0, 0));
    ticks(1);
    chk("level_at_100", mk(100, 0, 1, 1, 0, 0, 0));
    ticks(199);
    chk("level_before_300", mk(299, 0, 2, 1, 0, 0, 0));
    ticks(1);
    chk("level_at_300", mk(300, 0, 3, 1, 0, 0, 0));

    // saturation at 6399, level capped at 7
    ticks(6098);
    chk("score_6398", mk(6398, 0, 7, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      ticks(1);
      chk($sformatf("sat%0d", i), mk(6399, 0, 7, 1, 0, 0, 0));
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("hit_beats_pause", mk(6399, 6399, 7, 0, 1, 0, 1));
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("over_ignores_pause_hit", mk(6399, 6399, 7, 0, 1, 0, 1));

    reset_pulse();
    chk("reset_clears_hi", mk(0, 0, 0, 0, 0, 0, 0));
    @(posedge clk2);
    #1;
    reset = 1'b1;

    // record on first game, then tick+hit at 42 over hi 30
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(30);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("record_30", mk(30, 30, 0, 0, 1, 0, 1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart", mk(0, 30, 0, 1, 0, 0, 0));
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("start_held_in_run", mk(1, 30, 0, 1, 0, 0, 0));
    ticks(41);
    chk("score_42", mk(42, 30, 0, 1, 0, 0, 0));
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("tick_hit_42", mk(42, 42, 0, 0, 1, 0, 1));

    // build hi=50, then finish a game at 10
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(50);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("record_50", mk(50, 50, 0, 0, 1, 0, 1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(10);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("no_record_10", mk(10, 50, 0, 0, 1, 0, 0));
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("blink_idle_cycle", mk(10, 50, 0, 0, 1, 0, 0));

    // blink: 8 ticks per phase
    for (int i = 1; i <= 16; i++) begin
      logic sh;
      sh = (i >= 8) && (i < 16);
      ticks(1);
      chk($sformatf("blink%0d", i), mk(sh ? 50 : 10, 50, 0, 0, 1, sh, 0));
    end
    ticks(8);
    chk("blink_hi_again", mk(50, 50, 0, 0, 1, 1, 0));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_from_blink", mk(0, 50, 0, 1, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
